// File: rtl/keypad_frontend.sv
// Keypad and door-sensor front end: scans a 4x4 active-low matrix, debounces keys and door,
// and turns them into key/door events on a registered valid/ready stream.
package safe_pkg;
  typedef enum logic [3:0] {
    KEY_0       = 4'd0,
    KEY_1       = 4'd1,
    KEY_2       = 4'd2,
    KEY_3       = 4'd3,
    KEY_4       = 4'd4,
    KEY_5       = 4'd5,
    KEY_6       = 4'd6,
    KEY_7       = 4'd7,
    KEY_8       = 4'd8,
    KEY_9       = 4'd9,
    KEY_OK      = 4'd10,
    KEY_CLEAR   = 4'd11,
    DOOR_SEALED = 4'd12
  } data_in;
endpackage

module keypad_frontend #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  output logic [3:0]       col_o,
  input  logic [3:0]       row_i,
  input  logic             door_closed_i,
  output safe_pkg::data_in data_out_o,
  output logic             data_out_valid_o,
  input  logic             data_out_ready_i
);
  import safe_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, WAIT_REL, CLEAR_HOLD} state_e;
  typedef enum logic [1:0] {SRC_DOOR, SRC_KEY, SRC_CLEAR} src_e;

  function automatic logic [DB_W-1:0] sat_inc(input logic [DB_W-1:0] v);
    return (v == DB_MAX) ? v : v + DB_W'(1);
  endfunction

  // Snapshot bit index is col*4+row; column 3 (A-D) is never mapped.
  function automatic data_in code_of_idx(input logic [3:0] idx);
    case (idx)
      4'd0:    return KEY_1;
      4'd1:    return KEY_4;
      4'd2:    return KEY_7;
      4'd3:    return KEY_CLEAR;
      4'd4:    return KEY_2;
      4'd5:    return KEY_5;
      4'd6:    return KEY_8;
      4'd7:    return KEY_0;
      4'd8:    return KEY_3;
      4'd9:    return KEY_6;
      4'd10:   return KEY_9;
      4'd11:   return KEY_OK;
      default: return KEY_0;
    endcase
  endfunction

  logic [3:0]       row_s1_q, row_s2_q;
  logic             door_s1_q, door_s2_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [1:0]       col_q;
  logic [15:0]      snap_q, prev_q;
  logic             scan_stb_q;
  logic [DB_W-1:0]  key_cnt_q, key_cnt_d, door_cnt_q, door_cnt_d;
  logic [11:0]      keys_db_q;
  logic             door_prev_q, door_db_q;
  logic             tick, door_rise;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      door_s1_q <= 1'b0;
      door_s2_q <= 1'b0;
    end else begin
      row_s1_q  <= row_i;
      row_s2_q  <= row_s1_q;
      door_s1_q <= door_closed_i;
      door_s2_q <= door_s1_q;
    end
  end

  assign tick  = (div_cnt_q == DIV_LAST);
  assign col_o = ~(4'b0001 << col_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      div_cnt_q  <= '0;
      col_q      <= 2'd0;
      snap_q     <= '0;
      scan_stb_q <= 1'b0;
    end else begin
      div_cnt_q  <= tick ? '0 : div_cnt_q + DIV_W'(1);
      scan_stb_q <= tick && (col_q == 2'd3);
      if (tick) begin
        snap_q[{col_q, 2'b00} +: 4] <= ~row_s2_q;
        col_q                       <= col_q + 2'd1;
      end
    end
  end

  // Debounce: strobe fires one cycle after column 3 lands, so snap_q is a complete scan.
  always_comb begin
    key_cnt_d  = key_cnt_q;
    door_cnt_d = door_cnt_q;
    if (scan_stb_q) begin
      key_cnt_d  = (snap_q == prev_q) ? sat_inc(key_cnt_q) : '0;
      door_cnt_d = (door_s2_q == door_prev_q) ? sat_inc(door_cnt_q) : '0;
    end
  end

  assign door_rise = scan_stb_q && (door_cnt_d == DB_MAX) && door_s2_q && !door_db_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prev_q      <= '0;
      key_cnt_q   <= '0;
      keys_db_q   <= '0;
      door_prev_q <= 1'b0;
      door_cnt_q  <= '0;
      door_db_q   <= 1'b0;
    end else begin
      key_cnt_q  <= key_cnt_d;
      door_cnt_q <= door_cnt_d;
      if (scan_stb_q) begin
        prev_q      <= snap_q;
        door_prev_q <= door_s2_q;
        if (key_cnt_d == DB_MAX)  keys_db_q <= snap_q[11:0];
        if (door_cnt_d == DB_MAX) door_db_q <= door_s2_q;
      end
    end
  end

  logic [3:0] n_keys;
  logic       cls_none, cls_single, single_clear;
  data_in     key_code;

  always_comb begin
    n_keys       = 4'($countones(keys_db_q));
    cls_none     = (n_keys == 4'd0);
    cls_single   = (n_keys == 4'd1);
    single_clear = cls_single && keys_db_q[3];
    key_code     = KEY_0;
    for (int i = 0; i < 12; i++) begin
      if (keys_db_q[i]) key_code = code_of_idx(4'(i));
    end
  end

  state_e state_q, state_d;
  logic   key_set, clear_req;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (single_clear)                  state_d = CLEAR_HOLD;
        else if (!cls_none)                state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (cls_none)                      state_d = IDLE;
      end
      CLEAR_HOLD: begin
        if (cls_none)                      state_d = IDLE;
        else if (!single_clear)            state_d = WAIT_REL;
      end
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    key_set   = (state_q == IDLE) && cls_single && !single_clear;
    clear_req = (state_q == CLEAR_HOLD) && single_clear;
  end

  logic   valid_q, valid_d, hs;
  data_in data_q, data_d, key_code_q;
  src_e   src_q, src_d;
  logic   key_pend_q, door_pend_q, key_clr, door_clr, key_avail, door_avail;

  assign hs         = valid_q && data_out_ready_i;
  assign door_clr   = hs && (src_q == SRC_DOOR);
  assign key_clr    = hs && (src_q == SRC_KEY);
  assign door_avail = door_pend_q && !door_clr;
  assign key_avail  = key_pend_q && !key_clr;

  // A presented word is held until accepted, except a CLEAR whose hold has ended.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    if (valid_q && !data_out_ready_i) begin
      if (src_q == SRC_CLEAR && !clear_req) valid_d = 1'b0;
    end else begin
      valid_d = 1'b1;
      if (door_avail) begin
        data_d = DOOR_SEALED;
        src_d  = SRC_DOOR;
      end else if (key_avail) begin
        data_d = key_code_q;
        src_d  = SRC_KEY;
      end else if (clear_req) begin
        data_d = KEY_CLEAR;
        src_d  = SRC_CLEAR;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      valid_q     <= 1'b0;
      data_q      <= KEY_0;
      src_q       <= SRC_DOOR;
      key_pend_q  <= 1'b0;
      key_code_q  <= KEY_0;
      door_pend_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      src_q       <= src_d;
      door_pend_q <= door_rise || door_avail;
      key_pend_q  <= key_set || key_avail;
      if (key_set && !key_avail) key_code_q <= key_code;
    end
  end

  assign data_out_o       = data_q;
  assign data_out_valid_o = valid_q;

endmodule

// File: tb/tb_keypad_frontend.sv
// Self-checking bench for keypad_frontend: a keypad matrix model driven by random presses,
// with expected events derived from the printed key layout and the press/release history.
module tb_keypad_frontend;
  import safe_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int LAT      = (DEB + 2) * 4 * SCAN_DIV + 3;

  logic       clk_i = 1'b0;
  logic       arst_n_i;
  logic [3:0] col_o;
  logic [3:0] row_i;
  logic       door_closed_i;
  data_in     data_out_o;
  logic       data_out_valid_o;
  logic       data_out_ready_i;

  logic [15:0] held;   // bit r*4+c = key at row r, column c is pressed
  int          n_cmp = 0;
  int          n_bad = 0;
  data_in      hs_q[$];

  always #5 clk_i = ~clk_i;

  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  always @(negedge clk_i)
    if (arst_n_i && data_out_valid_o && data_out_ready_i) hs_q.push_back(data_out_o);

  keypad_frontend #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .col_o(col_o), .row_i(row_i),
    .door_closed_i(door_closed_i), .data_out_o(data_out_o),
    .data_out_valid_o(data_out_valid_o), .data_out_ready_i(data_out_ready_i)
  );

  function automatic int code_of(int r, int c);
    string s;
    byte   ch;
    case (r)
      0:       s = "123A";
      1:       s = "456B";
      2:       s = "789C";
      default: s = "*0#D";
    endcase
    ch = s.getc(c);
    if (ch >= "0" && ch <= "9") return int'(ch) - 48;
    if (ch == "#") return int'(KEY_OK);
    if (ch == "*") return int'(KEY_CLEAR);
    return -1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic pick_key(output int r, output int c);
    do begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 2);
    end while (code_of(r, c) == int'(KEY_CLEAR));
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    arst_n_i = 1'b0; held = '0; door_closed_i = 1'b0; data_out_ready_i = 1'b0;
    #12;
    n_cmp++; if (col_o !== 4'b1110) begin n_bad++; $display("FAIL reset_col got %b want 1110", col_o); end
    n_cmp++; if (data_out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", data_out_valid_o); end
    n_cmp++; if (data_out_o !== KEY_0) begin n_bad++; $display("FAIL reset_data got %0d want 0", data_out_o); end
    @(posedge clk_i); #2;
    arst_n_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      n_cmp++; if (col_o !== exp_col) begin n_bad++; $display("FAIL scan_col k=%0d got %b want %b", k, col_o, exp_col); end
      cyc(1);
    end
  endtask

  task automatic test_single_digit();
    int r, c, exp, hold;
    for (int it = 0; it < 5; it++) begin
      pick_key(r, c);
      exp = code_of(r, c);
      hs_q.delete();
      cyc($urandom_range(0, 15));
      held = 16'(1) << (r*4+c);
      hold = $urandom_range(150, 250);
      for (int i = 0; i < hold; i++) begin
        data_out_ready_i = 1'($urandom_range(0, 1));
        cyc(1);
      end
      held = '0;
      data_out_ready_i = 1'b1;
      cyc(150);
      n_cmp++; if (hs_q.size() != 1) begin n_bad++; $display("FAIL single_count key=%0d got %0d want 1", exp, hs_q.size()); end
      if (hs_q.size() > 0) begin
        n_cmp++; if (int'(hs_q[0]) !== exp) begin n_bad++; $display("FAIL single_code got %0d want %0d", hs_q[0], exp); end
      end
    end
  endtask

  task automatic test_bounce();
    hs_q.delete();
    data_out_ready_i = 1'b1;
    cyc($urandom_range(0, 15));
    for (int i = 0; i < 3; i++) begin
      held = (i % 2 == 0) ? (16'(1) << 14) : '0;
      cyc(1);
    end
    held = 16'(1) << 14;
    cyc(10);
    n_cmp++; if (hs_q.size() != 0) begin n_bad++; $display("FAIL bounce_early got %0d events want 0", hs_q.size()); end
    cyc(190);
    held = '0;
    cyc(150);
    n_cmp++; if (hs_q.size() != 1) begin n_bad++; $display("FAIL bounce_count got %0d want 1", hs_q.size()); end
    if (hs_q.size() > 0) begin
      n_cmp++; if (int'(hs_q[0]) !== code_of(3, 2)) begin n_bad++; $display("FAIL bounce_code got %0d want %0d", hs_q[0], code_of(3, 2)); end
    end
  endtask

  task automatic test_clear_hold();
    int elapsed, gaps, w, late, wrong;
    hs_q.delete();
    data_out_ready_i = 1'b1;
    cyc($urandom_range(0, 15));
    held = 16'(1) << 12;
    elapsed = 0;
    while (!data_out_valid_o && elapsed < LAT + 20) begin cyc(1); elapsed++; end
    n_cmp++; if (data_out_valid_o !== 1'b1) begin n_bad++; $display("FAIL clear_start got valid=%b want 1 within %0d", data_out_valid_o, LAT + 20); end
    gaps = 0;
    while (elapsed < 300) begin
      if (!data_out_valid_o) gaps++;
      cyc(1); elapsed++;
    end
    n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL clear_gaps got %0d want 0", gaps); end
    held = '0;
    w = 0;
    while (data_out_valid_o && w < LAT + 20) begin cyc(1); w++; end
    n_cmp++; if (data_out_valid_o !== 1'b0) begin n_bad++; $display("FAIL clear_stop got valid=%b want 0", data_out_valid_o); end
    late = 0;
    repeat (60) begin if (data_out_valid_o) late++; cyc(1); end
    n_cmp++; if (late != 0) begin n_bad++; $display("FAIL clear_after got %0d valid cycles want 0", late); end
    wrong = 0;
    foreach (hs_q[i]) if (hs_q[i] != KEY_CLEAR) wrong++;
    n_cmp++; if (wrong != 0) begin n_bad++; $display("FAIL clear_data got %0d non-CLEAR want 0", wrong); end
    n_cmp++; if (hs_q.size() < 300 - LAT - 20) begin n_bad++; $display("FAIL clear_len got %0d want >= %0d", hs_q.size(), 300 - LAT - 20); end
  endtask

  task automatic test_multi();
    int ra, ca, rb, cb, keep;
    pick_key(ra, ca);
    do pick_key(rb, cb); while (ra == rb && ca == cb);
    keep = $urandom_range(0, 1);
    hs_q.delete();
    data_out_ready_i = 1'b1;
    held = (16'(1) << (ra*4+ca)) | (16'(1) << (rb*4+cb));
    cyc(150);
    held = keep ? (16'(1) << (ra*4+ca)) : (16'(1) << (rb*4+cb));
    cyc(150);
    held = '0;
    cyc(150);
    n_cmp++; if (hs_q.size() != 0) begin n_bad++; $display("FAIL multi_none got %0d events want 0", hs_q.size()); end
    held = 16'(1) << 2;
    cyc(150);
    held = '0;
    cyc(150);
    n_cmp++; if (hs_q.size() != 1) begin n_bad++; $display("FAIL multi_after_count got %0d want 1", hs_q.size()); end
    if (hs_q.size() > 0) begin
      n_cmp++; if (int'(hs_q[0]) !== 3) begin n_bad++; $display("FAIL multi_after_code got %0d want 3", hs_q[0]); end
    end
  endtask

  task automatic test_door_in_clear();
    int doors, pos, wrong;
    hs_q.delete();
    data_out_ready_i = 1'b1;
    held = 16'(1) << 12;
    cyc(100 + $urandom_range(0, 20));
    door_closed_i = 1'b1;
    cyc(150);
    held = '0;
    cyc(150);
    doors = 0; pos = -1; wrong = 0;
    foreach (hs_q[i]) begin
      if (hs_q[i] == DOOR_SEALED) begin doors++; pos = i; end
      else if (hs_q[i] != KEY_CLEAR) wrong++;
    end
    n_cmp++; if (doors != 1) begin n_bad++; $display("FAIL door_count got %0d want 1", doors); end
    n_cmp++; if (wrong != 0) begin n_bad++; $display("FAIL door_other got %0d stray events want 0", wrong); end
    n_cmp++; if (!(pos > 0 && pos < hs_q.size() - 1)) begin n_bad++; $display("FAIL door_inside got pos %0d of %0d want inside stream", pos, hs_q.size()); end
    hs_q.delete();
    door_closed_i = 1'b0;
    cyc(150);
    n_cmp++; if (hs_q.size() != 0) begin n_bad++; $display("FAIL door_open got %0d events want 0", hs_q.size()); end
  endtask

  task automatic test_backpressure();
    int w, bad;
    hs_q.delete();
    data_out_ready_i = 1'b0;
    held = 16'(1) << 8;
    w = 0;
    while (!data_out_valid_o && w < LAT + 20) begin cyc(1); w++; end
    n_cmp++; if (data_out_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %b want 1", data_out_valid_o); end
    n_cmp++; if (int'(data_out_o) !== code_of(2, 0)) begin n_bad++; $display("FAIL bp_data got %0d want %0d", data_out_o, code_of(2, 0)); end
    bad = 0;
    repeat (50) begin
      if (!data_out_valid_o || int'(data_out_o) !== code_of(2, 0)) bad++;
      cyc(1);
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    data_out_ready_i = 1'b1;
    cyc(20);
    n_cmp++; if (hs_q.size() != 1) begin n_bad++; $display("FAIL bp_count got %0d want 1", hs_q.size()); end
    if (hs_q.size() > 0) begin
      n_cmp++; if (int'(hs_q[0]) !== code_of(2, 0)) begin n_bad++; $display("FAIL bp_code got %0d want %0d", hs_q[0], code_of(2, 0)); end
    end
    n_cmp++; if (data_out_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_after got valid=%b want 0", data_out_valid_o); end
    held = '0;
    cyc(150);
  endtask

  task automatic test_reset_midstream();
    int w;
    data_out_ready_i = 1'b1;
    held = 16'(1) << 12;
    w = 0;
    while (!data_out_valid_o && w < LAT + 20) begin cyc(1); w++; end
    n_cmp++; if (data_out_valid_o !== 1'b1) begin n_bad++; $display("FAIL rst_stream got valid=%b want 1", data_out_valid_o); end
    cyc(20 + $urandom_range(0, 7));
    #1 arst_n_i = 1'b0;
    #1;
    n_cmp++; if (data_out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", data_out_valid_o); end
    n_cmp++; if (col_o !== 4'b1110) begin n_bad++; $display("FAIL rst_col got %b want 1110", col_o); end
    n_cmp++; if (data_out_o !== KEY_0) begin n_bad++; $display("FAIL rst_data got %0d want 0", data_out_o); end
    cyc(3);
    held = '0;
    arst_n_i = 1'b1;
    hs_q.delete();
    cyc(150);
    n_cmp++; if (hs_q.size() != 0) begin n_bad++; $display("FAIL rst_after got %0d events want 0", hs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_bounce();
    test_clear_hold();
    test_multi();
    test_door_in_clear();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
